// File: rtl/ioif_pad_frontend_pkg.sv
// Shared types and reset constants for the pad-side ioif terminator.
// Pad config travels through unchanged; only anamode is interpreted here.
package pad_pkg;

    typedef struct packed {
        logic       anamode;
        logic [1:0] drive;
        logic       slew;
        logic       schmitt;
    } padcfg_arm_t;

    localparam logic PAD_PO_RST = 1'b1;
    localparam logic PAD_OE_RST = 1'b0;
    localparam logic PAD_PU_RST = 1'b1;

    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } filt_state_e;

endpackage

// File: rtl/ioif_pad_frontend_if.sv
// ioif link between a peripheral (master) and the pad frontend (load).
// po/oe/pu flow peripheral->pad; pi flows pad->peripheral. Levels, no handshake.
interface ioif;
    logic po;
    logic oe;
    logic pu;
    logic pi;

    modport master (output po, output oe, output pu, input pi);
    modport load   (input po, input oe, input pu, output pi);
endinterface

// File: rtl/ioif_pad_frontend_filter.sv
// Glitch filter: pi follows sync_i only after it has differed for len_i cycles.
// Events are registered and coincide with the cycle pi takes its new value.
module ioif_glitch_filter
    import pad_pkg::*;
#(
    parameter int FILT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync_i,
    input  logic [FILT_W-1:0] len_i,
    input  logic              anamode_i,
    output logic              pi_o,
    output logic              evt_rise_o,
    output logic              evt_fall_o,
    output filt_state_e       state_o
);

    filt_state_e       state_q, state_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic              pi_q, pi_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            pi_q    <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pi_q    <= pi_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pi_d    = pi_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (anamode_i) begin
            // Analog pads present a constant high and never raise events.
            state_d = STABLE;
            cnt_d   = '0;
            pi_d    = 1'b1;
        end else begin
            case (state_q)
                STABLE: begin
                    if (sync_i != pi_q) begin
                        if (len_i == FILT_W'(1)) begin
                            pi_d   = sync_i;
                            rise_d = sync_i;
                            fall_d = ~sync_i;
                        end else begin
                            cnt_d   = FILT_W'(1);
                            state_d = PEND;
                        end
                    end
                end
                PEND: begin
                    if (sync_i == pi_q) begin
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else if (cnt_q >= len_i - FILT_W'(1)) begin
                        pi_d    = sync_i;
                        rise_d  = sync_i;
                        fall_d  = ~sync_i;
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + FILT_W'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end
            endcase
        end
    end

    assign pi_o       = pi_q;
    assign evt_rise_o = rise_q;
    assign evt_fall_o = fall_q;
    assign state_o    = state_q;

endmodule

// File: rtl/ioif_pad_frontend.sv
// Pad-side terminator of the ioif link: registers the output path onto the pad
// wires and returns a synchronised, glitch-filtered pad_in as ioifld.pi.
module ioif_pad_frontend
    import pad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    ioif.load                 ioifld,
    input  padcfg_arm_t       padcfg,
    input  logic              filt_en,
    input  logic [FILT_W-1:0] filt_len,
    output logic              pad_out,
    output logic              pad_oe,
    output logic              pad_pu,
    output padcfg_arm_t       pad_cfg,
    input  logic              pad_in,
    output logic              evt_rise,
    output logic              evt_fall,
    output filt_state_e       dbg_filt_state
);

    logic                   pad_out_q, pad_oe_q, pad_pu_q;
    padcfg_arm_t            pad_cfg_q;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILT_W-1:0]      len_eff;
    logic                   pi;

    // Analog mode always tri-states the digital driver.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_out_q <= PAD_PO_RST;
            pad_oe_q  <= PAD_OE_RST;
            pad_pu_q  <= PAD_PU_RST;
            pad_cfg_q <= '0;
        end else begin
            pad_out_q <= ioifld.po;
            pad_oe_q  <= ioifld.oe & ~padcfg.anamode;
            pad_pu_q  <= ioifld.pu;
            pad_cfg_q <= padcfg;
        end
    end

    assign sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= sync_d;
    end

    assign len_eff = (filt_en && filt_len != '0) ? filt_len : FILT_W'(1);

    ioif_glitch_filter #(.FILT_W(FILT_W)) u_filt (
        .clk        (clk),
        .reset      (reset),
        .sync_i     (sync_q[SYNC_STAGES-1]),
        .len_i      (len_eff),
        .anamode_i  (padcfg.anamode),
        .pi_o       (pi),
        .evt_rise_o (evt_rise),
        .evt_fall_o (evt_fall),
        .state_o    (dbg_filt_state)
    );

    assign ioifld.pi = pi;
    assign pad_out   = pad_out_q;
    assign pad_oe    = pad_oe_q;
    assign pad_pu    = pad_pu_q;
    assign pad_cfg   = pad_cfg_q;

endmodule
